// File: rtl/mems_scan_seq.sv
// MEMS mirror scan sequencer: issues init then scan command addresses to an SPI core
// and raises sticky line/frame marker events as the scan passes marker addresses.
module mems_scan_seq #(
  parameter int ADDR_W          = 16,
  parameter int INIT_CMDS       = 2,
  parameter int SCAN_START      = 8,
  parameter int SCAN_END        = 8804,
  parameter int FIRST_LINE      = 562,
  parameter int LINE_PITCH      = 880,
  parameter int LINES_PER_FRAME = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_reset,
  input  logic              pause,
  input  logic              oneshot,
  input  logic              spi_busy,
  input  logic              line_ack,
  input  logic              frame_ack,
  output logic              spi_start,
  output logic [ADDR_W-1:0] addr,
  output logic              new_line,
  output logic              new_frame,
  output logic [7:0]        line_idx,
  output logic [15:0]       frame_cnt,
  output logic              overrun,
  output logic              done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [ADDR_W-1:0] LP_INIT_CMDS  = ADDR_W'(INIT_CMDS);
  localparam logic [ADDR_W-1:0] LP_SCAN_START = ADDR_W'(SCAN_START);
  localparam logic [ADDR_W-1:0] LP_SCAN_END   = ADDR_W'(SCAN_END);
  // Marker arithmetic carries one extra bit so a marker past the end cannot alias back
  localparam logic [ADDR_W:0]   LP_FIRST      = (ADDR_W+1)'(FIRST_LINE);
  localparam logic [ADDR_W:0]   LP_PITCH      = (ADDR_W+1)'(LINE_PITCH);
  localparam logic [ADDR_W:0]   LP_END_X      = (ADDR_W+1)'(SCAN_END);
  localparam logic [7:0]        LP_LPF_M1     = 8'(LINES_PER_FRAME - 1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_init_idx;
  logic              r_spi_start;
  logic              r_done;
  logic              r_new_line;
  logic              r_new_frame;
  logic              r_overrun;
  logic [7:0]        r_line_idx;
  logic [15:0]       r_frame_cnt;
  logic [ADDR_W:0]   r_next_marker;
  logic [7:0]        r_kmod;

  logic              w_permit;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic              w_start_nxt;
  logic              w_done_nxt;
  logic              w_scan_issue;
  logic              w_wrap;
  logic              w_abort;
  logic [ADDR_W:0]   w_mk_cur;
  logic [7:0]        w_k_cur;
  logic              w_hit;
  logic              w_frame_hit;

  // A registered pulse blocks the following cycle, guaranteeing an idle gap
  assign w_permit = !spi_busy && !r_spi_start;

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_idx_nxt    = r_init_idx;
    w_start_nxt  = 1'b0;
    w_done_nxt   = r_done;
    w_scan_issue = 1'b0;
    w_wrap       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_addr_nxt = '0;
        w_done_nxt = 1'b0;
        if (soft_reset) begin
          w_state_nxt = ST_INIT;
          w_idx_nxt   = '0;
          w_abort     = 1'b1;
        end
      end
      ST_INIT: begin
        if (soft_reset) begin
          w_idx_nxt = '0;
          w_abort   = 1'b1;
        end else if (w_permit) begin
          w_start_nxt = 1'b1;
          if (r_init_idx < LP_INIT_CMDS) begin
            w_addr_nxt = r_init_idx;
            w_idx_nxt  = r_init_idx + 1'b1;
          end else begin
            w_addr_nxt   = LP_SCAN_START;
            w_state_nxt  = ST_SCAN;
            w_scan_issue = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (soft_reset) begin
          w_state_nxt = ST_INIT;
          w_idx_nxt   = '0;
          w_abort     = 1'b1;
        end else if (w_permit && !pause) begin
          if (r_addr == LP_SCAN_END) begin
            w_wrap = 1'b1;
            if (oneshot) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_start_nxt  = 1'b1;
              w_addr_nxt   = LP_SCAN_START;
              w_scan_issue = 1'b1;
            end
          end else begin
            w_start_nxt  = 1'b1;
            w_addr_nxt   = r_addr + 1'b1;
            w_scan_issue = 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_done_nxt = 1'b1;
        if (soft_reset) begin
          w_state_nxt = ST_INIT;
          w_idx_nxt   = '0;
          w_done_nxt  = 1'b0;
          w_abort     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_addr_nxt  = '0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  // On a wrap the tracker restarts in the same cycle, so the first scan address can hit
  assign w_mk_cur    = w_wrap ? LP_FIRST : r_next_marker;
  assign w_k_cur     = w_wrap ? 8'd0 : r_kmod;
  assign w_hit       = w_scan_issue && (w_mk_cur == {1'b0, w_addr_nxt}) && (w_mk_cur <= LP_END_X);
  assign w_frame_hit = w_hit && (w_k_cur == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_init_idx    <= '0;
      r_spi_start   <= 1'b0;
      r_done        <= 1'b0;
      r_new_line    <= 1'b0;
      r_new_frame   <= 1'b0;
      r_overrun     <= 1'b0;
      r_line_idx    <= 8'd0;
      r_frame_cnt   <= 16'd0;
      r_next_marker <= LP_FIRST;
      r_kmod        <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_init_idx  <= w_idx_nxt;
      r_spi_start <= w_start_nxt;
      r_done      <= w_done_nxt;
      if (w_abort) begin
        r_new_line    <= 1'b0;
        r_new_frame   <= 1'b0;
        r_overrun     <= 1'b0;
        r_line_idx    <= 8'd0;
        r_next_marker <= LP_FIRST;
        r_kmod        <= 8'd0;
      end else begin
        if (w_wrap)
          r_frame_cnt <= r_frame_cnt + 16'd1;
        if (w_hit) begin
          r_next_marker <= w_mk_cur + LP_PITCH;
          r_kmod        <= (w_k_cur == LP_LPF_M1) ? 8'd0 : w_k_cur + 8'd1;
          r_line_idx    <= w_k_cur;
        end else if (w_wrap) begin
          r_next_marker <= LP_FIRST;
          r_kmod        <= 8'd0;
        end
        // Setting beats a simultaneous acknowledge
        if (w_hit)
          r_new_line <= 1'b1;
        else if (line_ack)
          r_new_line <= 1'b0;
        if (w_frame_hit)
          r_new_frame <= 1'b1;
        else if (frame_ack)
          r_new_frame <= 1'b0;
        if (w_hit && r_new_line && !line_ack)
          r_overrun <= 1'b1;
      end
    end
  end

  assign spi_start = r_spi_start;
  assign addr      = r_addr;
  assign new_line  = r_new_line;
  assign new_frame = r_new_frame;
  assign line_idx  = r_line_idx;
  assign frame_cnt = r_frame_cnt;
  assign overrun   = r_overrun;
  assign done      = r_done;

endmodule

// File: tb/tb_mems_scan_seq.sv
// Directed bench for mems_scan_seq with a simple SPI busy responder.
module tb_mems_scan_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        soft_reset = 1'b0;
  logic        pause = 1'b0;
  logic        oneshot = 1'b0;
  logic        spi_busy;
  logic        line_ack = 1'b0;
  logic        frame_ack = 1'b0;
  logic        spi_start;
  logic [15:0] addr;
  logic        new_line;
  logic        new_frame;
  logic [7:0]  line_idx;
  logic [15:0] frame_cnt;
  logic        overrun;
  logic        done;

  int n_vec = 0;
  int n_err = 0;
  int busy_len = 3;
  int busy_cnt = 0;

  mems_scan_seq dut (
    .clk(clk), .rst_n(rst_n), .soft_reset(soft_reset), .pause(pause), .oneshot(oneshot),
    .spi_busy(spi_busy), .line_ack(line_ack), .frame_ack(frame_ack), .spi_start(spi_start),
    .addr(addr), .new_line(new_line), .new_frame(new_frame), .line_idx(line_idx),
    .frame_cnt(frame_cnt), .overrun(overrun), .done(done)
  );

  always #5 clk = ~clk;

  // SPI core model: busy rises the cycle after spi_start and lasts busy_len cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (spi_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign spi_busy = (busy_cnt > 0);

  task automatic run_to(input logic [15:0] tgt, input bit any, input bit auto_ack,
                        output bit found, output logic [15:0] got, output int cyc);
    found = 1'b0;
    got   = '0;
    cyc   = 0;
    for (int i = 0; i < 40000 && !found; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (spi_start && (any || addr == tgt)) begin
        found = 1'b1;
        got   = addr;
      end else if (auto_ack) begin
        line_ack  = new_line;
        frame_ack = new_frame;
      end
    end
    line_ack  = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic pulse_soft();
    @(posedge clk); #1 soft_reset = 1'b1;
    @(posedge clk); #1 soft_reset = 1'b0;
  endtask

  task automatic test_reset();
    int pulses = 0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (spi_start !== 1'b0) begin n_err++; $display("FAIL rst_spi_start got %b want 0", spi_start); end
    n_vec++; if (addr !== 16'd0) begin n_err++; $display("FAIL rst_addr got %0d want 0", addr); end
    n_vec++; if ({new_line, new_frame, overrun, done} !== 4'b0) begin n_err++; $display("FAIL rst_flags got %b want 0000", {new_line, new_frame, overrun, done}); end
    n_vec++; if ({line_idx, frame_cnt} !== 24'd0) begin n_err++; $display("FAIL rst_counts got %0d/%0d want 0/0", line_idx, frame_cnt); end
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (spi_start) pulses++; end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL idle_no_issue got %0d pulses want 0", pulses); end
  endtask

  task automatic test_init_seq();
    logic [15:0] exp_a [5] = '{16'd0, 16'd1, 16'd8, 16'd9, 16'd10};
    bit found; logic [15:0] got; int cyc;
    pulse_soft();
    for (int i = 0; i < 5; i++) begin
      run_to(16'd0, 1'b1, 1'b0, found, got, cyc);
      n_vec++; if (!found || got !== exp_a[i]) begin n_err++; $display("FAIL init_addr[%0d] got %0d want %0d", i, got, exp_a[i]); end
      if (i > 0) begin
        n_vec++; if (cyc !== 5) begin n_err++; $display("FAIL init_gap[%0d] got %0d cycles want 5", i, cyc); end
      end
    end
    busy_len = 0;
  endtask

  task automatic test_markers();
    bit found; logic [15:0] got; int cyc;
    run_to(16'd562, 1'b0, 1'b1, found, got, cyc);
    n_vec++; if (!found || {new_line, new_frame, line_idx} !== {2'b11, 8'd0}) begin n_err++; $display("FAIL mk562 got nl=%b nf=%b idx=%0d want 1 1 0", new_line, new_frame, line_idx); end
    line_ack = 1'b1; frame_ack = 1'b1;
    @(posedge clk); #1;
    line_ack = 1'b0; frame_ack = 1'b0;
    n_vec++; if ({new_line, new_frame} !== 2'b00) begin n_err++; $display("FAIL ack_clear got %b want 00", {new_line, new_frame}); end
    run_to(16'd1442, 1'b0, 1'b0, found, got, cyc);
    n_vec++; if (!found || {new_line, new_frame, line_idx, overrun} !== {2'b10, 8'd1, 1'b0}) begin n_err++; $display("FAIL mk1442 got nl=%b nf=%b idx=%0d ov=%b want 1 0 1 0", new_line, new_frame, line_idx, overrun); end
    run_to(16'd4962, 1'b0, 1'b1, found, got, cyc);
    n_vec++; if (!found || {new_line, new_frame, line_idx, overrun} !== {2'b11, 8'd0, 1'b0}) begin n_err++; $display("FAIL mk4962 got nl=%b nf=%b idx=%0d ov=%b want 1 1 0 0", new_line, new_frame, line_idx, overrun); end
  endtask

  task automatic test_wrap();
    bit found; logic [15:0] got; int cyc;
    oneshot = 1'b0;
    run_to(16'd8804, 1'b0, 1'b1, found, got, cyc);
    n_vec++; if (!found || frame_cnt !== 16'd0) begin n_err++; $display("FAIL end_reached found=%b frame_cnt=%0d want 1/0", found, frame_cnt); end
    run_to(16'd0, 1'b1, 1'b0, found, got, cyc);
    n_vec++; if (!found || got !== 16'd8 || frame_cnt !== 16'd1) begin n_err++; $display("FAIL wrap got addr=%0d fc=%0d want 8/1", got, frame_cnt); end
    run_to(16'd562, 1'b0, 1'b1, found, got, cyc);
    n_vec++; if (!found || {new_line, new_frame, line_idx} !== {2'b11, 8'd0}) begin n_err++; $display("FAIL wrap_mk562 got nl=%b nf=%b idx=%0d want 1 1 0", new_line, new_frame, line_idx); end
  endtask

  task automatic test_overrun();
    bit found; logic [15:0] got; int cyc;
    pulse_soft();
    n_vec++; if ({new_line, new_frame, overrun} !== 3'b000) begin n_err++; $display("FAIL soft_clear got %b want 000", {new_line, new_frame, overrun}); end
    run_to(16'd562, 1'b0, 1'b0, found, got, cyc);
    n_vec++; if (!found || overrun !== 1'b0) begin n_err++; $display("FAIL ov_before got %b want 0", overrun); end
    run_to(16'd1442, 1'b0, 1'b0, found, got, cyc);
    n_vec++; if (!found || overrun !== 1'b1) begin n_err++; $display("FAIL ov_1442 got %b want 1", overrun); end
    run_to(16'd2321, 1'b0, 1'b0, found, got, cyc);
    @(posedge clk); #1 line_ack = 1'b1;
    @(posedge clk); #1 line_ack = 1'b0;
    n_vec++; if (!found || spi_start !== 1'b1 || addr !== 16'd2322) begin n_err++; $display("FAIL issue_2322 got start=%b addr=%0d want 1/2322", spi_start, addr); end
    n_vec++; if (new_line !== 1'b1 || overrun !== 1'b1) begin n_err++; $display("FAIL set_wins got nl=%b ov=%b want 1 1", new_line, overrun); end
  endtask

  task automatic test_pause_soft();
    bit found; logic [15:0] got; int cyc; int bad = 0;
    pulse_soft();
    run_to(16'd100, 1'b0, 1'b1, found, got, cyc);
    pause = 1'b1;
    repeat (50) begin @(posedge clk); #1; if (spi_start || addr !== 16'd100) bad++; end
    pause = 1'b0;
    n_vec++; if (!found || bad !== 0) begin n_err++; $display("FAIL pause_hold got %0d bad cycles want 0", bad); end
    run_to(16'd0, 1'b1, 1'b0, found, got, cyc);
    n_vec++; if (!found || got !== 16'd101) begin n_err++; $display("FAIL pause_resume got %0d want 101", got); end
    run_to(16'd2999, 1'b0, 1'b0, found, got, cyc);
    busy_len = 3;
    run_to(16'd3000, 1'b0, 1'b0, found, got, cyc);
    n_vec++; if (!found || overrun !== 1'b1) begin n_err++; $display("FAIL ov_3000 got %b want 1", overrun); end
    pulse_soft();
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL soft_ov got %b want 0", overrun); end
    run_to(16'd0, 1'b1, 1'b0, found, got, cyc);
    busy_len = 0;
    n_vec++; if (!found || got !== 16'd0 || cyc !== 3) begin n_err++; $display("FAIL restart got addr=%0d after %0d cycles want 0 after 3", got, cyc); end
    n_vec++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL fc_kept got %0d want 1", frame_cnt); end
  endtask

  task automatic test_async_reset();
    bit found; logic [15:0] got; int cyc; int pulses = 0;
    run_to(16'd3000, 1'b0, 1'b1, found, got, cyc);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (!found || spi_start !== 1'b0 || addr !== 16'd0) begin n_err++; $display("FAIL arst_addr got start=%b addr=%0d want 0/0", spi_start, addr); end
    n_vec++; if ({new_line, new_frame, overrun, done, line_idx, frame_cnt} !== 28'd0) begin n_err++; $display("FAIL arst_state got fc=%0d idx=%0d flags=%b want zeros", frame_cnt, line_idx, {new_line, new_frame, overrun, done}); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; if (spi_start) pulses++; end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL arst_no_issue got %0d pulses want 0", pulses); end
  endtask

  task automatic test_oneshot();
    bit found; logic [15:0] got; int cyc; int pulses = 0;
    oneshot = 1'b1;
    pulse_soft();
    run_to(16'd8804, 1'b0, 1'b1, found, got, cyc);
    repeat (20) begin @(posedge clk); #1; if (spi_start) pulses++; end
    n_vec++; if (!found || pulses !== 0) begin n_err++; $display("FAIL oneshot_stop got %0d pulses want 0", pulses); end
    n_vec++; if (done !== 1'b1 || addr !== 16'd8804 || frame_cnt !== 16'd1) begin n_err++; $display("FAIL oneshot_done got done=%b addr=%0d fc=%0d want 1/8804/1", done, addr, frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_init_seq();
    test_markers();
    test_wrap();
    test_overrun();
    test_pause_soft();
    test_async_reset();
    test_oneshot();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
